// File: rtl/axi_read_arbiter.sv
// Two-master round-robin arbiter for a single AXI read port (AR + R).
// One burst in flight; the grant is held from AR acceptance through the last R beat.
module axi_read_arbiter #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDRESS_WIDTH-1:0] m0_araddr,
    input  logic [7:0]               m0_arlen,
    input  logic [2:0]               m0_arsize,
    input  logic [1:0]               m0_arburst,
    input  logic                     m0_arvalid,
    output logic                     m0_arready,
    output logic [DATA_WIDTH-1:0]    m0_rdata,
    output logic [1:0]               m0_rresp,
    output logic                     m0_rlast,
    output logic                     m0_rvalid,
    input  logic                     m0_rready,
    input  logic [ADDRESS_WIDTH-1:0] m1_araddr,
    input  logic [7:0]               m1_arlen,
    input  logic [2:0]               m1_arsize,
    input  logic [1:0]               m1_arburst,
    input  logic                     m1_arvalid,
    output logic                     m1_arready,
    output logic [DATA_WIDTH-1:0]    m1_rdata,
    output logic [1:0]               m1_rresp,
    output logic                     m1_rlast,
    output logic                     m1_rvalid,
    input  logic                     m1_rready,
    output logic [ADDRESS_WIDTH-1:0] s_araddr,
    output logic [7:0]               s_arlen,
    output logic [2:0]               s_arsize,
    output logic [1:0]               s_arburst,
    output logic                     s_arvalid,
    input  logic                     s_arready,
    input  logic [DATA_WIDTH-1:0]    s_rdata,
    input  logic [1:0]               s_rresp,
    input  logic                     s_rlast,
    input  logic                     s_rvalid,
    output logic                     s_rready,
    output logic                     grant,
    output logic                     busy,
    output logic                     len_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_grant;
    logic       r_last_grant;
    logic       r_len_err;
    logic [7:0] r_beat_cnt;
    logic [7:0] r_burst_len;
    logic       w_ar_hs;
    logic       w_r_hs;

    assign w_ar_hs = s_arvalid & s_arready;
    assign w_r_hs  = s_rvalid & s_rready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_beat_cnt   <= 8'd0;
            r_burst_len  <= 8'd0;
            r_len_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0_arvalid || m1_arvalid) begin
                        r_state <= ADDR;
                        // On a tie the master that did not win last time goes first.
                        if (m0_arvalid && m1_arvalid)
                            r_grant <= ~r_last_grant;
                        else
                            r_grant <= m1_arvalid;
                    end
                end
                ADDR: begin
                    if (w_ar_hs) begin
                        r_burst_len <= s_arlen;
                        r_beat_cnt  <= 8'd0;
                        r_state     <= DATA;
                    end
                end
                DATA: begin
                    if (w_r_hs) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (s_rlast) begin
                            if (r_beat_cnt != r_burst_len)
                                r_len_err <= 1'b1;
                            r_last_grant <= r_grant;
                            r_state      <= IDLE;
                        end else if (r_beat_cnt == r_burst_len) begin
                            // Expected last beat arrived without rlast; keep draining until it shows.
                            r_len_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_araddr   = '0;
        s_arlen    = '0;
        s_arsize   = '0;
        s_arburst  = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = '0;
        m0_rlast   = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = '0;
        m1_rlast   = 1'b0;
        m1_rvalid  = 1'b0;
        if (r_state == ADDR) begin
            if (r_grant) begin
                s_araddr   = m1_araddr;
                s_arlen    = m1_arlen;
                s_arsize   = m1_arsize;
                s_arburst  = m1_arburst;
                s_arvalid  = m1_arvalid;
                m1_arready = s_arready;
            end else begin
                s_araddr   = m0_araddr;
                s_arlen    = m0_arlen;
                s_arsize   = m0_arsize;
                s_arburst  = m0_arburst;
                s_arvalid  = m0_arvalid;
                m0_arready = s_arready;
            end
        end
        // R path is pure wiring so backpressure costs no extra cycle.
        if (r_state == DATA) begin
            if (r_grant) begin
                m1_rdata  = s_rdata;
                m1_rresp  = s_rresp;
                m1_rlast  = s_rlast;
                m1_rvalid = s_rvalid;
                s_rready  = m1_rready;
            end else begin
                m0_rdata  = s_rdata;
                m0_rresp  = s_rresp;
                m0_rlast  = s_rlast;
                m0_rvalid = s_rvalid;
                s_rready  = m0_rready;
            end
        end
    end

    assign grant   = r_grant;
    assign busy    = (r_state != IDLE);
    assign len_err = r_len_err;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: behavioural slave plus per-master beat scoreboards.
module tb_axi_read_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          aclk, areset;
    logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
    logic [7:0]    m0_arlen, m1_arlen, s_arlen;
    logic [2:0]    m0_arsize, m1_arsize, s_arsize;
    logic [1:0]    m0_arburst, m1_arburst, s_arburst;
    logic          m0_arvalid, m1_arvalid, s_arvalid;
    logic          m0_arready, m1_arready, s_arready;
    logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]    m0_rresp, m1_rresp, s_rresp;
    logic          m0_rlast, m1_rlast, s_rlast;
    logic          m0_rvalid, m1_rvalid, s_rvalid;
    logic          m0_rready, m1_rready, s_rready;
    logic          grant, busy, len_err;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    beat_t   q0[$];
    beat_t   q1[$];
    int      gq[$];
    int      n_checks = 0;
    int      n_pass   = 0;
    int      sl_override = -1;
    logic    sl_active;
    logic [AW-1:0] sl_addr;
    int      sl_beat, sl_last_at;

    axi_read_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .areset(areset),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic beat_t mk_beat(input logic [7:0] addr, input int b, input int nb);
        beat_t r;
        logic [31:0] bv;
        bv     = b;
        r.data = {16'hC0DE, addr, bv[7:0]};
        r.resp = {1'b0, bv[0]};
        r.last = (b == nb - 1);
        return r;
    endfunction

    // Slave: handshakes observed at the negedge complete on the following posedge.
    task automatic slave_model();
        logic ar_p, r_p;
        logic [7:0] a_p, l_p;
        logic [31:0] sb;
        forever begin
            @(negedge aclk);
            ar_p = !areset && s_arvalid && s_arready;
            r_p  = !areset && s_rvalid && s_rready;
            a_p  = s_araddr;
            l_p  = s_arlen;
            @(posedge aclk);
            #1;
            if (areset) begin
                sl_active = 1'b0;
            end else begin
                if (r_p) begin
                    if (s_rlast) sl_active = 1'b0;
                    else sl_beat++;
                end
                if (ar_p) begin
                    sl_active  = 1'b1;
                    sl_addr    = a_p;
                    sl_beat    = 0;
                    sl_last_at = (sl_override >= 0) ? sl_override : int'(l_p);
                end
            end
            sb        = sl_beat;
            s_arready = !sl_active;
            s_rvalid  = sl_active;
            s_rdata   = {16'hC0DE, sl_addr, sb[7:0]};
            s_rresp   = {1'b0, sb[0]};
            s_rlast   = sl_active && (sl_beat == sl_last_at);
        end
    endtask

    task automatic monitor();
        beat_t e;
        logic saw_last;
        saw_last = 1'b0;
        forever begin
            @(negedge aclk);
            if (!areset) begin
                if (saw_last) begin
                    n_checks++;
                    if (busy !== 1'b0) $display("FAIL idle_gap: busy %0b after rlast, required 0", busy);
                    else n_pass++;
                    saw_last = 1'b0;
                end
                if (s_arvalid && s_arready) gq.push_back(int'(grant));
                if (m0_rvalid && q0.size() == 0) begin
                    n_checks++;
                    $display("FAIL m0_unexpected_beat: rvalid=1 data %h, required rvalid=0", m0_rdata);
                end else if (m0_rvalid && m0_rready) begin
                    e = q0.pop_front();
                    n_checks++;
                    if (m0_rdata !== e.data || m0_rresp !== e.resp || m0_rlast !== e.last)
                        $display("FAIL m0_beat: got %h/%0d/%0b, required %h/%0d/%0b",
                                 m0_rdata, m0_rresp, m0_rlast, e.data, e.resp, e.last);
                    else n_pass++;
                    if (m0_rlast) saw_last = 1'b1;
                end
                if (m1_rvalid && q1.size() == 0) begin
                    n_checks++;
                    $display("FAIL m1_unexpected_beat: rvalid=1 data %h, required rvalid=0", m1_rdata);
                end else if (m1_rvalid && m1_rready) begin
                    e = q1.pop_front();
                    n_checks++;
                    if (m1_rdata !== e.data || m1_rresp !== e.resp || m1_rlast !== e.last)
                        $display("FAIL m1_beat: got %h/%0d/%0b, required %h/%0d/%0b",
                                 m1_rdata, m1_rresp, m1_rlast, e.data, e.resp, e.last);
                    else n_pass++;
                    if (m1_rlast) saw_last = 1'b1;
                end
            end
        end
    endtask

    task automatic issue(input int m, input logic [7:0] addr, input logic [7:0] len, input int nb);
        logic ok;
        ok = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (m == 0) q0.push_back(mk_beat(addr, b, nb));
            else q1.push_back(mk_beat(addr, b, nb));
        end
        if (m == 0) begin
            m0_araddr = addr; m0_arlen = len; m0_arsize = 3'd2; m0_arburst = 2'd1; m0_arvalid = 1'b1;
        end else begin
            m1_araddr = addr; m1_arlen = len; m1_arsize = 3'd2; m1_arburst = 2'd1; m1_arvalid = 1'b1;
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge aclk);
            if ((m == 0) ? (m0_arvalid && m0_arready) : (m1_arvalid && m1_arready)) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge aclk);
        #1;
        if (m == 0) m0_arvalid = 1'b0;
        else m1_arvalid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL ar_timeout_m%0d: no AR handshake, required one within 300 cycles", m);
        end
    endtask

    task automatic wait_done(input string name);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge aclk);
            #1;
            if (q0.size() == 0 && q1.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL %s_drain: pending %0d/%0d busy %0b, required 0/0 busy 0",
                          name, q0.size(), q1.size(), busy);
        else n_pass++;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        q0.delete();
        q1.delete();
        sl_override = -1;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic test_reset();
        areset     = 1'b1;
        m0_arvalid = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %0b, required 0", busy); else n_pass++;
        n_checks++;
        if (grant !== 1'b0) $display("FAIL reset_grant: got %0b, required 0", grant); else n_pass++;
        n_checks++;
        if (len_err !== 1'b0) $display("FAIL reset_len_err: got %0b, required 0", len_err); else n_pass++;
        n_checks++;
        if ({s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid} !== 6'b0)
            $display("FAIL reset_handshakes: got %b, required 000000",
                     {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid});
        else n_pass++;
        @(posedge aclk);
        #1;
        areset     = 1'b0;
        m0_arvalid = 1'b0;
    endtask

    task automatic test_single();
        for (int b = 0; b < 5; b++) q0.push_back(mk_beat(8'h00, b, 5));
        m0_araddr = 8'h00; m0_arlen = 8'd4; m0_arsize = 3'd2; m0_arburst = 2'd1; m0_arvalid = 1'b1;
        @(negedge aclk);
        n_checks++;
        if ({s_arvalid, m0_arready, busy} !== 3'b000)
            $display("FAIL single_arb_cycle: arvalid/arready/busy %b, required 000", {s_arvalid, m0_arready, busy});
        else n_pass++;
        @(negedge aclk);
        n_checks++;
        if ({s_arvalid, m0_arready, m1_arready, grant} !== 4'b1100)
            $display("FAIL single_addr: arvalid/m0rdy/m1rdy/grant %b, required 1100",
                     {s_arvalid, m0_arready, m1_arready, grant});
        else n_pass++;
        n_checks++;
        if (s_araddr !== 8'h00 || s_arlen !== 8'd4 || s_arsize !== 3'd2 || s_arburst !== 2'd1)
            $display("FAIL single_ar_fields: got %h/%0d/%0d/%0d, required 00/4/2/1",
                     s_araddr, s_arlen, s_arsize, s_arburst);
        else n_pass++;
        @(posedge aclk);
        #1;
        m0_arvalid = 1'b0;
        wait_done("single");
        n_checks++;
        if (len_err !== 1'b0) $display("FAIL single_len_err: got %0b, required 0", len_err); else n_pass++;
    endtask

    task automatic test_tie();
        do_reset();
        gq.delete();
        fork
            issue(0, 8'h11, 8'd1, 2);
            issue(1, 8'h22, 8'd2, 3);
        join
        wait_done("tie");
        n_checks++;
        if (gq.size() != 2 || gq[0] != 0 || gq[1] != 1)
            $display("FAIL tie_order: got %p, required '{0,1}", gq);
        else n_pass++;
    endtask

    task automatic test_alternate();
        do_reset();
        gq.delete();
        fork
            for (int i = 0; i < 3; i++) issue(0, 8'(8'h60 + i), 8'd1, 2);
            for (int i = 0; i < 3; i++) issue(1, 8'(8'h70 + i), 8'd1, 2);
        join
        wait_done("alternate");
        n_checks++;
        if (gq.size() != 6) $display("FAIL alt_count: got %0d grants, required 6", gq.size());
        else n_pass++;
        for (int i = 0; i < gq.size(); i++) begin
            n_checks++;
            if (gq[i] != i % 2) $display("FAIL alt_grant%0d: got %0d, required %0d", i, gq[i], i % 2);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        issue(1, 8'h40, 8'd3, 4);
        for (int c = 0; c < 40 && busy; c++) begin
            @(negedge aclk);
            if (!busy) break;
            n_checks++;
            if (s_rready !== m1_rready || m1_rvalid !== s_rvalid)
                $display("FAIL bp_passthru: s_rready %0b m1_rvalid %0b, required %0b and %0b",
                         s_rready, m1_rvalid, m1_rready, s_rvalid);
            else n_pass++;
            @(posedge aclk);
            #1;
            m1_rready = ~m1_rready;
        end
        m1_rready = 1'b1;
        wait_done("backpressure");
    endtask

    task automatic test_long();
        issue(0, 8'h10, 8'hFF, 256);
        wait_done("long");
        n_checks++;
        if (len_err !== 1'b0) $display("FAIL long_len_err: got %0b, required 0", len_err); else n_pass++;
    endtask

    task automatic test_len_err();
        sl_override = 2;
        issue(0, 8'h20, 8'd4, 3);
        wait_done("short");
        n_checks++;
        if (len_err !== 1'b1 || busy !== 1'b0)
            $display("FAIL short_rlast: len_err/busy %b, required 10", {len_err, busy});
        else n_pass++;
        sl_override = -1;
        issue(1, 8'h24, 8'd1, 2);
        wait_done("after_short");
        n_checks++;
        if (len_err !== 1'b1) $display("FAIL len_err_sticky: got %0b, required 1", len_err); else n_pass++;
        do_reset();
        n_checks++;
        if (len_err !== 1'b0) $display("FAIL len_err_clear: got %0b, required 0", len_err); else n_pass++;
    endtask

    task automatic test_overrun();
        sl_override = 3;
        issue(0, 8'h30, 8'd2, 4);
        wait_done("overrun");
        n_checks++;
        if (len_err !== 1'b1) $display("FAIL overrun_len_err: got %0b, required 1", len_err); else n_pass++;
        do_reset();
    endtask

    task automatic test_reset_mid_data();
        logic ok;
        ok = 1'b0;
        issue(0, 8'h50, 8'd4, 5);
        for (int c = 0; c < 50; c++) begin
            @(posedge aclk);
            #1;
            if (q0.size() == 3) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL mid_two_beats: pending %0d, required 3", q0.size()); else n_pass++;
        areset    = 1'b1;
        m0_rready = 1'b0;
        q0.delete();
        @(posedge aclk);
        @(negedge aclk);
        n_checks++;
        if (busy !== 1'b0 || grant !== 1'b0) $display("FAIL mid_reset_state: busy/grant %b, required 00", {busy, grant});
        else n_pass++;
        n_checks++;
        if ({m0_rvalid, m1_rvalid, m0_arready, m1_arready, s_arvalid, s_rready} !== 6'b0)
            $display("FAIL mid_reset_outputs: got %b, required 000000",
                     {m0_rvalid, m1_rvalid, m0_arready, m1_arready, s_arvalid, s_rready});
        else n_pass++;
        @(posedge aclk);
        #1;
        areset    = 1'b0;
        m0_rready = 1'b1;
        gq.delete();
        fork
            issue(0, 8'h5A, 8'd0, 1);
            issue(1, 8'h5B, 8'd0, 1);
        join
        wait_done("post_reset_tie");
        n_checks++;
        if (gq.size() != 2 || gq[0] != 0) $display("FAIL post_reset_first_grant: got %p, required '{0,1}", gq);
        else n_pass++;
    endtask

    initial begin
        areset = 1'b1;
        m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
        m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
        s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
        sl_active = 1'b0; sl_addr = '0; sl_beat = 0; sl_last_at = 0;
        fork
            monitor();
            slave_model();
        join_none
        test_reset();
        test_single();
        test_tie();
        test_alternate();
        test_backpressure();
        test_long();
        test_len_err();
        test_overrun();
        test_reset_mid_data();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1ms, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Two-master arbiter sharing the single AXI read port (AR + R channels) of axi_slave_ram.
- Sits between two read requesters (m0, m1) and the slave (s_).
- Round-robin grant per burst; the grant is held from AR acceptance until the last R beat.
- One burst in flight at a time; per-burst beat counting flags rlast mismatches.

Parameters:
ADDRESS_WIDTH, 8, width of araddr on all ports
DATA_WIDTH, 32, width of rdata on all ports

Ports:
aclk  input  1  clock, all logic on rising edge
areset  input  1  synchronous active-high reset
m0_araddr / m1_araddr  input  ADDRESS_WIDTH  master read address
m0_arlen / m1_arlen  input  8  burst length minus one
m0_arsize / m1_arsize  input  3  beat size
m0_arburst / m1_arburst  input  2  burst type
m0_arvalid / m1_arvalid  input  1  AR valid
m0_arready / m1_arready  output  1  AR ready
m0_rdata / m1_rdata  output  DATA_WIDTH  read data
m0_rresp / m1_rresp  output  2  read response
m0_rlast / m1_rlast  output  1  last beat
m0_rvalid / m1_rvalid  output  1  R valid
m0_rready / m1_rready  input  1  R ready
s_araddr, s_arlen, s_arsize, s_arburst  output  ADDRESS_WIDTH/8/3/2  forwarded AR fields
s_arvalid  output  1  AR valid to slave
s_arready  input  1  AR ready from slave
s_rdata, s_rresp, s_rlast, s_rvalid  input  DATA_WIDTH/2/1/1  R from slave
s_rready  output  1  R ready to slave
grant  output  1  index of the current or last granted master
busy  output  1  high in ADDR or DATA
len_err  output  1  sticky: rlast position disagreed with arlen

Behaviour:
- States are IDLE, ADDR and DATA. Registers: state, grant, last_grant, beat_cnt[7:0], burst_len[7:0], len_err.
- Reset (areset=1 at a clock edge), regardless of current state:
  - state=IDLE, grant=0, last_grant=1 (so m0 wins the first tie), beat_cnt=0, len_err=0.
  - All valid/ready outputs are 0 while in IDLE.
- IDLE:
  - If exactly one mX_arvalid=1, grant<=X.
  - If both are 1, grant<=~last_grant.
  - Go to ADDR next cycle. With no request, stay in IDLE.
  - Arbitration costs exactly one cycle: no ready is asserted in IDLE.
- ADDR:
  - s_ar* are driven combinationally from the granted master.
  - s_arvalid = granted mX_arvalid; granted mX_arready = s_arready; the other master's arready = 0.
  - On s_arvalid & s_arready: latch burst_len<=arlen, beat_cnt<=0, go to DATA.
  - If the granted master drops arvalid (a protocol violation), stay in ADDR holding the grant.
- DATA:
  - Granted master: mX_rdata/rresp/rlast/rvalid = s_r*; s_rready = granted mX_rready.
  - Non-granted master: rvalid=0, arready=0, and its other R outputs are 0.
  - Each s_rvalid & s_rready does beat_cnt<=beat_cnt+1.
  - On a handshake with s_rlast=1:
    - If beat_cnt != burst_len, set len_err<=1.
    - Go to IDLE; last_grant<=grant.
  - On a handshake with beat_cnt==burst_len and s_rlast=0: set len_err<=1 and stay in DATA until rlast.
- s_ar* outputs are 0 when not in ADDR. s_rready=0 when not in DATA.
- busy = (state!=IDLE). grant holds its value in IDLE.
- Back-to-back bursts: after the rlast handshake, at least one IDLE cycle follows before the next AR.
- Backpressure: the arbiter adds no R-path register. Stall passes through combinationally, so zero latency is added on R.
- beat_cnt is 8-bit. burst_len=255 gives 256 beats with no overflow before compare.
- Reset mid-ADDR or mid-DATA aborts to IDLE immediately; outstanding slave beats are not drained.

Test Plan:
- Only m0 requests, arlen=4, araddr=0, rready=1 -> one IDLE cycle, then s_arvalid=1; m0 receives 5 beats, rlast on the 5th; m1_rvalid stays 0; len_err=0.
- m0 and m1 raise arvalid in the same cycle right after reset -> grant=0 first, m0 burst completes, then grant=1 and the m1 burst runs.
- Both keep requesting continuously with arlen=1 -> grants alternate 0,1,0,1; each burst gives 2 beats; one IDLE cycle between bursts.
- m1 granted, arlen=3, m1_rready toggles 1,0,1,0 -> s_rready mirrors m1_rready in the same cycle; 4 beats are delivered with no loss or duplication.
- Slave asserts rlast on beat 3 with arlen=4 -> len_err=1 and state returns to IDLE. len_err stays 1 through a later correct burst until reset.
- areset=1 in DATA after 2 of 5 beats -> next cycle: state=IDLE, busy=0, all rvalid/arready/s_arvalid=0, last_grant=1.
